// File: rtl/apb_protocol_monitor.sv
// Passive APB3/APB4 protocol monitor: tracks the transfer phase on a multi-slave
// bus, raises sticky per-rule violation flags and captures the first error.
module apb_protocol_monitor #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NS         = 4,
  parameter int MAXSTALL   = 16,
  parameter bit OPT_APB4   = 1'b1,
  parameter bit OPT_SLVERR = 1'b1,
  localparam int SW        = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic [NS-1:0]   PSEL,
  input  logic            PENABLE,
  input  logic [NS-1:0]   PREADY,
  input  logic [NS-1:0]   PSLVERR,
  input  logic [AW-1:0]   PADDR,
  input  logic            PWRITE,
  input  logic [DW-1:0]   PWDATA,
  input  logic [DW/8-1:0] PWSTRB,
  input  logic [2:0]      PPROT,
  input  logic            i_clear,
  output logic            o_err,
  output logic [7:0]      o_err_flags,
  output logic [2:0]      o_err_code,
  output logic [SW-1:0]   o_err_sel,
  output logic [AW-1:0]   o_err_addr,
  output logic [31:0]     o_xfer_count
);

  localparam int STW = (MAXSTALL > 0) ? $clog2(MAXSTALL + 1) : 1;
  localparam logic [STW-1:0] STALL_MAX  = STW'(MAXSTALL);
  localparam logic [STW-1:0] STALL_LAST = STW'((MAXSTALL > 0) ? MAXSTALL - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  // r_state is the phase of the previous sampled cycle; w_phase is the phase of
  // the cycle being sampled now, and becomes r_state on the next edge.
  state_t          r_state;
  state_t          w_phase;
  logic            r_done;
  logic [SW-1:0]   r_sel;
  logic [STW-1:0]  r_stall;

  logic [AW-1:0]   r_paddr;
  logic            r_pwrite;
  logic [DW-1:0]   r_pwdata;
  logic [DW/8-1:0] r_pwstrb;
  logic [2:0]      r_pprot;

  logic [7:0]      r_flags;
  logic [2:0]      r_code;
  logic [SW-1:0]   r_err_sel;
  logic [AW-1:0]   r_err_addr;
  logic [31:0]     r_xfer;

  logic [SW-1:0]   w_sel;
  logic [SW-1:0]   w_err_sel;
  logic            w_any;
  logic            w_multi;
  logic            w_track;
  logic            w_hold_viol;
  logic            w_changed;
  logic            w_complete;
  logic            w_stalled;
  logic [7:0]      w_viol;
  logic [2:0]      w_code;

  assign w_any   = |PSEL;
  assign w_multi = |(PSEL & (PSEL - NS'(1)));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (PSEL[i]) w_sel = SW'(i);
    end
  end

  // A transfer is in flight when the last cycle was setup or a stalled access.
  assign w_track     = (r_state == ST_SETUP) || ((r_state == ST_ACCESS) && !r_done);
  assign w_hold_viol = w_track && (!PSEL[r_sel] || (w_sel != r_sel));

  // State register
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_sel   <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_phase;
      r_done  <= w_complete;
      if (w_phase == ST_SETUP) r_sel <= w_sel;
      if (w_stalled) r_stall <= (r_stall == STALL_MAX) ? r_stall : r_stall + STW'(1);
      else           r_stall <= '0;
    end
  end

  // Next-state logic; a hold violation resynchronises onto the current PSEL.
  always_comb begin
    w_phase = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_phase = w_any ? ST_SETUP : ST_IDLE;
      ST_SETUP: begin
        if (w_hold_viol) w_phase = w_any ? ST_SETUP : ST_IDLE;
        else             w_phase = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (r_done || w_hold_viol) w_phase = w_any ? ST_SETUP : ST_IDLE;
        else                       w_phase = ST_ACCESS;
      end
      default:   w_phase = ST_IDLE;
    endcase
  end

  // Output logic of the FSM
  always_comb begin
    w_complete = 1'b0;
    w_stalled  = 1'b0;
    w_err_sel  = w_sel;
    if (w_phase == ST_ACCESS) begin
      w_complete = PREADY[r_sel];
      w_stalled  = !PREADY[r_sel];
      w_err_sel  = r_sel;
    end
  end

  always_comb begin
    w_changed = (PADDR != r_paddr) || (PWRITE != r_pwrite) ||
                (OPT_APB4 && (PPROT != r_pprot)) ||
                (r_pwrite && ((PWDATA != r_pwdata) || (OPT_APB4 && (PWSTRB != r_pwstrb))));
  end

  always_comb begin
    w_viol    = '0;
    w_viol[0] = w_multi;
    w_viol[1] = ((r_state == ST_IDLE) && w_any && PENABLE) ||
                ((r_state == ST_SETUP) && !PENABLE);
    w_viol[2] = w_hold_viol;
    w_viol[3] = w_track && w_changed;
    w_viol[4] = r_done && PENABLE;
    w_viol[5] = (MAXSTALL != 0) && w_stalled && (r_stall == STALL_LAST);
    w_viol[6] = (w_any && PSLVERR[w_err_sel] && !w_complete) ||
                (!OPT_SLVERR && (|PSLVERR));
    w_viol[7] = OPT_APB4 && w_any && !PWRITE && (|PWSTRB);
  end

  // Lowest-numbered rule wins when several fire together.
  always_comb begin
    w_code = '0;
    for (int i = 7; i >= 0; i--) begin
      if (w_viol[i]) w_code = 3'(i);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_paddr    <= '0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= '0;
      r_pwstrb   <= '0;
      r_pprot    <= '0;
      r_flags    <= '0;
      r_code     <= '0;
      r_err_sel  <= '0;
      r_err_addr <= '0;
      r_xfer     <= '0;
    end else begin
      r_paddr  <= PADDR;
      r_pwrite <= PWRITE;
      r_pwdata <= PWDATA;
      r_pwstrb <= PWSTRB;
      r_pprot  <= PPROT;

      if (w_complete && (r_xfer != '1)) r_xfer <= r_xfer + 32'd1;

      if (i_clear) r_flags <= w_viol;
      else         r_flags <= r_flags | w_viol;

      if ((|w_viol) && ((r_flags == '0) || i_clear)) begin
        r_code     <= w_code;
        r_err_sel  <= w_err_sel;
        r_err_addr <= PADDR;
      end else if (i_clear) begin
        r_code     <= '0;
        r_err_sel  <= '0;
        r_err_addr <= '0;
      end
    end
  end

  assign o_err        = |r_flags;
  assign o_err_flags  = r_flags;
  assign o_err_code   = r_code;
  assign o_err_sel    = r_err_sel;
  assign o_err_addr   = r_err_addr;
  assign o_xfer_count = r_xfer;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Scoreboard bench for apb_protocol_monitor: each driven cycle pushes the
// expected post-edge outputs, which are popped and compared after the edge.
module tb_apb_protocol_monitor;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int SW = 2;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [NS-1:0]   PSEL;
  logic            PENABLE;
  logic [NS-1:0]   PREADY;
  logic [NS-1:0]   PSLVERR;
  logic [AW-1:0]   PADDR;
  logic            PWRITE;
  logic [DW-1:0]   PWDATA;
  logic [DW/8-1:0] PWSTRB;
  logic [2:0]      PPROT;
  logic            i_clear;
  logic            o_err;
  logic [7:0]      o_err_flags;
  logic [2:0]      o_err_code;
  logic [SW-1:0]   o_err_sel;
  logic [AW-1:0]   o_err_addr;
  logic [31:0]     o_xfer_count;

  apb_protocol_monitor #(
    .AW(AW), .DW(DW), .NS(NS), .MAXSTALL(4), .OPT_APB4(1'b1), .OPT_SLVERR(1'b1)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PWSTRB(PWSTRB), .PPROT(PPROT), .i_clear(i_clear),
    .o_err(o_err), .o_err_flags(o_err_flags), .o_err_code(o_err_code),
    .o_err_sel(o_err_sel), .o_err_addr(o_err_addr), .o_xfer_count(o_xfer_count)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string         tag;
    logic [7:0]    flags;
    logic [2:0]    code;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [31:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic bus(input logic [NS-1:0] sel, input logic en, input logic [NS-1:0] rdy,
                     input logic [NS-1:0] err, input logic [AW-1:0] addr, input logic wr,
                     input logic [DW-1:0] wdata, input logic [DW/8-1:0] strb, input logic clr);
    PSEL    = sel;
    PENABLE = en;
    PREADY  = rdy;
    PSLVERR = err;
    PADDR   = addr;
    PWRITE  = wr;
    PWDATA  = wdata;
    PWSTRB  = strb;
    i_clear = clr;
  endtask

  task automatic idle(input logic clr);
    bus(4'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, clr);
  endtask

  task automatic compare_head();
    exp_t e;
    e = exp_q.pop_front();
    check({e.tag, ".flags"}, 32'(o_err_flags),  32'(e.flags));
    check({e.tag, ".err"},   32'(o_err),        32'(|e.flags));
    check({e.tag, ".code"},  32'(o_err_code),   32'(e.code));
    check({e.tag, ".sel"},   32'(o_err_sel),    32'(e.sel));
    check({e.tag, ".addr"},  32'(o_err_addr),   32'(e.addr));
    check({e.tag, ".count"}, o_xfer_count,      e.cnt);
  endtask

  task automatic step_exp(input string tag, input logic [7:0] flags, input logic [2:0] code,
                          input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                          input logic [31:0] cnt);
    exp_t e;
    e.tag   = tag;
    e.flags = flags;
    e.code  = code;
    e.sel   = sel;
    e.addr  = addr;
    e.cnt   = cnt;
    exp_q.push_back(e);
    @(posedge PCLK);
    #1;
    compare_head();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    PPROT  = 3'b000;
    PRESET = 1'b1;
    // Garbage during reset must be ignored
    bus(4'b0101, 1'b1, 4'h0, 4'hF, 32'hFFFF, 1'b0, 32'h0, 4'hF, 1'b0);
    step_exp("reset", 8'h00, 3'd0, 2'd0, 32'h0, 32'd0);
    PRESET = 1'b0;
    idle(1'b0);
    step_exp("post_reset", 8'h00, 3'd0, 2'd0, 32'h0, 32'd0);

    // Single write to slave 1, PSLVERR during completion is legal
    bus(4'b0010, 1'b0, 4'h0, 4'h0, 32'h40, 1'b1, 32'hDEAD, 4'hF, 1'b0);
    step_exp("wr_setup", 8'h00, 3'd0, 2'd0, 32'h0, 32'd0);
    bus(4'b0010, 1'b1, 4'b0010, 4'b0010, 32'h40, 1'b1, 32'hDEAD, 4'hF, 1'b0);
    step_exp("wr_access", 8'h00, 3'd0, 2'd0, 32'h0, 32'd1);
    idle(1'b0);
    step_exp("wr_idle", 8'h00, 3'd0, 2'd0, 32'h0, 32'd1);

    // Two selects at once
    bus(4'b0101, 1'b0, 4'h0, 4'h0, 32'h200, 1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    check("onehot_latency", 32'(o_err), 32'd0);
    step_exp("onehot_setup", 8'h01, 3'd0, 2'd0, 32'h200, 32'd1);
    bus(4'b0101, 1'b1, 4'b0001, 4'h0, 32'h200, 1'b0, 32'h0, 4'h0, 1'b0);
    step_exp("onehot_access", 8'h01, 3'd0, 2'd0, 32'h200, 32'd2);
    idle(1'b0);
    step_exp("onehot_sticky", 8'h01, 3'd0, 2'd0, 32'h200, 32'd2);
    idle(1'b1);
    step_exp("onehot_clear", 8'h00, 3'd0, 2'd0, 32'h0, 32'd2);

    // PADDR changes during a stalled access
    bus(4'b0100, 1'b0, 4'h0, 4'h0, 32'h100, 1'b1, 32'h1, 4'hF, 1'b0);
    step_exp("stable_setup", 8'h00, 3'd0, 2'd0, 32'h0, 32'd2);
    bus(4'b0100, 1'b1, 4'h0, 4'h0, 32'h100, 1'b1, 32'h1, 4'hF, 1'b0);
    step_exp("stable_wait", 8'h00, 3'd0, 2'd0, 32'h0, 32'd2);
    bus(4'b0100, 1'b1, 4'h0, 4'h0, 32'h104, 1'b1, 32'h1, 4'hF, 1'b0);
    step_exp("stable_change", 8'h08, 3'd3, 2'd2, 32'h104, 32'd2);
    bus(4'b0100, 1'b1, 4'b0100, 4'h0, 32'h104, 1'b1, 32'h1, 4'hF, 1'b0);
    step_exp("stable_done", 8'h08, 3'd3, 2'd2, 32'h104, 32'd3);
    idle(1'b1);
    step_exp("stable_clear", 8'h00, 3'd0, 2'd0, 32'h0, 32'd3);

    // Timeout after 4 stalled access cycles, flagged only once
    bus(4'b1000, 1'b0, 4'h0, 4'h0, 32'h300, 1'b0, 32'h0, 4'h0, 1'b0);
    step_exp("to_setup", 8'h00, 3'd0, 2'd0, 32'h0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      bus(4'b1000, 1'b1, 4'h0, 4'h0, 32'h300, 1'b0, 32'h0, 4'h0, 1'b0);
      step_exp($sformatf("to_wait%0d", i), 8'h00, 3'd0, 2'd0, 32'h0, 32'd3);
    end
    bus(4'b1000, 1'b1, 4'h0, 4'h0, 32'h300, 1'b0, 32'h0, 4'h0, 1'b0);
    step_exp("to_fire", 8'h20, 3'd5, 2'd3, 32'h300, 32'd3);
    bus(4'b1000, 1'b1, 4'h0, 4'h0, 32'h300, 1'b0, 32'h0, 4'h0, 1'b1);
    step_exp("to_once", 8'h00, 3'd0, 2'd0, 32'h0, 32'd3);
    bus(4'b1000, 1'b1, 4'b1000, 4'h0, 32'h300, 1'b0, 32'h0, 4'h0, 1'b0);
    step_exp("to_done", 8'h00, 3'd0, 2'd0, 32'h0, 32'd4);
    idle(1'b0);
    step_exp("to_idle", 8'h00, 3'd0, 2'd0, 32'h0, 32'd4);

    // Read with strobes and PSLVERR in setup
    bus(4'b0001, 1'b0, 4'h0, 4'b0001, 32'h50, 1'b0, 32'h0, 4'hF, 1'b0);
    step_exp("se_setup", 8'hC0, 3'd6, 2'd0, 32'h50, 32'd4);
    bus(4'b0001, 1'b1, 4'b0001, 4'h0, 32'h50, 1'b0, 32'h0, 4'hF, 1'b0);
    step_exp("se_done", 8'hC0, 3'd6, 2'd0, 32'h50, 32'd5);
    idle(1'b1);
    step_exp("se_clear", 8'h00, 3'd0, 2'd0, 32'h0, 32'd5);

    // PENABLE high in setup, then PENABLE held after completion while clearing
    bus(4'b0001, 1'b1, 4'h0, 4'h0, 32'h70, 1'b1, 32'h5, 4'hF, 1'b0);
    step_exp("su_penable", 8'h02, 3'd1, 2'd0, 32'h70, 32'd5);
    bus(4'b0001, 1'b1, 4'b0001, 4'h0, 32'h70, 1'b1, 32'h5, 4'hF, 1'b0);
    step_exp("su_done", 8'h02, 3'd1, 2'd0, 32'h70, 32'd6);
    bus(4'h0, 1'b1, 4'h0, 4'h0, 32'h74, 1'b0, 32'h0, 4'h0, 1'b1);
    step_exp("enhold_clear", 8'h10, 3'd4, 2'd0, 32'h74, 32'd6);
    idle(1'b1);
    step_exp("enhold_clear2", 8'h00, 3'd0, 2'd0, 32'h0, 32'd6);

    // Select switches slaves mid-transfer, then resynchronises
    bus(4'b0010, 1'b0, 4'h0, 4'h0, 32'h80, 1'b0, 32'h0, 4'h0, 1'b0);
    step_exp("hold_setup", 8'h00, 3'd0, 2'd0, 32'h0, 32'd6);
    bus(4'b0100, 1'b1, 4'h0, 4'h0, 32'h80, 1'b0, 32'h0, 4'h0, 1'b0);
    step_exp("hold_switch", 8'h04, 3'd2, 2'd2, 32'h80, 32'd6);
    bus(4'b0100, 1'b1, 4'b0100, 4'h0, 32'h80, 1'b0, 32'h0, 4'h0, 1'b0);
    step_exp("hold_resync", 8'h04, 3'd2, 2'd2, 32'h80, 32'd7);
    idle(1'b1);
    step_exp("hold_clear", 8'h00, 3'd0, 2'd0, 32'h0, 32'd7);

    // Reset in the middle of an access
    bus(4'b0001, 1'b0, 4'h0, 4'h0, 32'h90, 1'b1, 32'h7, 4'hF, 1'b0);
    step_exp("rst_setup", 8'h00, 3'd0, 2'd0, 32'h0, 32'd7);
    bus(4'b0001, 1'b1, 4'h0, 4'b0001, 32'h90, 1'b1, 32'h7, 4'hF, 1'b0);
    step_exp("rst_err", 8'h40, 3'd6, 2'd0, 32'h90, 32'd7);
    PRESET = 1'b1;
    bus(4'b0001, 1'b1, 4'b0001, 4'h0, 32'h90, 1'b1, 32'h7, 4'hF, 1'b0);
    step_exp("rst_mid", 8'h00, 3'd0, 2'd0, 32'h0, 32'd0);
    PRESET = 1'b0;
    idle(1'b0);
    step_exp("rst_idle", 8'h00, 3'd0, 2'd0, 32'h0, 32'd0);
    bus(4'b0010, 1'b0, 4'h0, 4'h0, 32'hA0, 1'b1, 32'h9, 4'hF, 1'b0);
    step_exp("fresh_setup", 8'h00, 3'd0, 2'd0, 32'h0, 32'd0);
    bus(4'b0010, 1'b1, 4'b0010, 4'h0, 32'hA0, 1'b1, 32'h9, 4'hF, 1'b0);
    step_exp("fresh_done", 8'h00, 3'd0, 2'd0, 32'h0, 32'd1);
    idle(1'b0);
    step_exp("fresh_idle", 8'h00, 3'd0, 2'd0, 32'h0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_protocol_monitor.md
# apb_protocol_monitor

Synthesizable, multi-slave APB3/APB4 protocol monitor. It passively observes a master-side APB bus with NS select lines and flags protocol violations in sticky hardware registers. Its counters and first-error capture make bus problems visible in silicon and in simulation without a formal tool. It sits beside an APB interconnect, tapping all signals, and drives nothing onto the bus.

## Interface
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- NS, 4, number of PSEL lines / slaves (1..16)
- MAXSTALL, 16, max consecutive not-ready access cycles; 0 disables the timeout check
- OPT_APB4, 1, enables PWSTRB/PPROT checks; 0 forces rule 7 off and ignores PWSTRB/PPROT
- OPT_SLVERR, 1, 0 makes any PSLVERR assertion an error

Ports:
- PCLK  in  1  clock; everything is on the rising edge
- PRESET  in  1  reset; one clock; reset is synchronous and active-high
- PSEL  in  NS  slave selects
- PENABLE  in  1  access phase
- PREADY  in  NS  per-slave ready
- PSLVERR  in  NS  per-slave error
- PADDR  in  AW  address
- PWRITE  in  1  direction
- PWDATA  in  DW  write data
- PWSTRB  in  DW/8  write strobes
- PPROT  in  3  protection
- i_clear  in  1  clears sticky flags and capture
- o_err  out  1  OR of o_err_flags
- o_err_flags  out  8  sticky per-rule flags
- o_err_code  out  3  rule number of the first error since the last clear
- o_err_sel  out  max(1,$clog2(NS))  PSEL index at the first error
- o_err_addr  out  AW  PADDR at the first error
- o_xfer_count  out  32  completed transfers, saturating at 32'hFFFF_FFFF

## Operation
- FSM: IDLE, SETUP, ACCESS. It tracks the selected index `sel` (the lowest set PSEL bit).
- IDLE → SETUP when any PSEL is set.
- SETUP → ACCESS unconditionally.
- ACCESS with PREADY[sel] high is completion:
  - o_xfer_count increments.
  - The next state is SETUP if PSEL is still set, else IDLE.
- ACCESS with PREADY[sel] low stays in ACCESS and increments the stall counter. The stall counter clears on any other state.
- Rules, each sampled every cycle:
  - 0 ONEHOT: more than one PSEL bit is set.
  - 1 SETUP: in IDLE, PSEL is set with PENABLE high; or in SETUP, PENABLE is low.
  - 2 HOLD: in SETUP, or in ACCESS not completing, the next cycle has PSEL[sel] low or a different index selected.
  - 3 STABLE: while the previous cycle was SETUP or a stalled ACCESS, any of these changed: PADDR, PWRITE, PPROT (only when OPT_APB4), or, when PWRITE, PWDATA or PWSTRB (only when OPT_APB4).
  - 4 ENHOLD: the cycle after a completion, PENABLE is high.
  - 5 TIMEOUT: the stall counter reaches MAXSTALL. This flags once per transfer.
  - 6 SLVERR: PSLVERR[sel] is high when not (ACCESS and PREADY[sel]); or, with OPT_SLVERR=0, any PSLVERR bit is high at all.
  - 7 STRB: OPT_APB4, PSEL set, PWRITE low, PWSTRB nonzero.
- Non-selected slaves' PREADY/PSLVERR are ignored, except under rule 6 with OPT_SLVERR=0.
- After a HOLD violation, the FSM resynchronises: it goes to SETUP if PSEL is set, else IDLE.
- Flags are sticky until i_clear or PRESET.
- Capture: the o_err_code/sel/addr registers load only when no flag is set, or when clearing.
  - If multiple rules fire in one cycle, the lowest-numbered rule wins.
- i_clear together with a new violation: flags = new violations only, and the capture loads the new error. Errors win over clear.
- i_clear does not reset o_xfer_count; only PRESET does.

## Timing
- Reset values: all outputs 0, FSM IDLE, stall counter 0.
- Any input in the PRESET cycle is ignored.
- The first cycle after reset compares against IDLE. There is no "previous" sample for rule 3.
- Latency: a violation sampled at edge N appears on o_err_flags/o_err at the output after edge N, i.e. 1 cycle. Capture registers update on the same edge.
- o_xfer_count updates on the edge that samples completion.
- PRESET mid-transfer aborts tracking. The transfer is not counted and no error is flagged.
- Stall counter width: $clog2(MAXSTALL+1). It saturates at MAXSTALL.

## Test plan
- Single write: PSEL=4'b0010, SETUP then ACCESS with PREADY[1]=1 → o_xfer_count=1, o_err=0.
- Two selects: PSEL=4'b0101 → flag bit 0, o_err_code=0, o_err_sel=0, with 1-cycle latency.
- PADDR changes from 0x100 to 0x104 during a stalled ACCESS → flag bit 3, o_err_addr=0x104, transfer still counts on completion.
- MAXSTALL=4, PREADY low for 4 access cycles → flag bit 5 set once; o_err_code=5.
- Read with PWSTRB=4'hF and PSLVERR[sel] high in SETUP → flags bits 6 and 7, o_err_code=6; i_clear with no new error → all flags 0, o_xfer_count unchanged.
- PRESET asserted in the middle of ACCESS → all outputs 0 on the next cycle; a fresh legal transfer then counts 1.
